// File: rtl/fe_buf_wr_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the feature-buffer write controller.
package fe_buf_wr_ctrl_pkg;

  localparam int unsigned FE_IFM_WIDTH   = 8;
  localparam int unsigned FE_SCH_COL_NUM = 40;
  localparam int unsigned FE_PE_IC_NUM   = 4;
  localparam int unsigned FE_ADDR_WIDTH  = 10;
  localparam int unsigned FE_HALF_DEPTH  = 1 << (FE_ADDR_WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Number of bank groups a tile row occupies: ceil(ch / ic).
  function automatic logic [14:0] ceil_div_ic(input logic [14:0] ch, input int unsigned ic);
    logic [31:0] sum;
    sum = 32'(ch) + ic - 32'd1;
    return 15'(sum / ic);
  endfunction

endpackage

// File: rtl/fe_buf_half_trk.sv
// Ping-pong half tracker: full flags plus write/read half pointers.
module fe_buf_half_trk (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       rel,
  input  logic       cmpl,
  output logic [1:0] full,
  output logic [1:0] full_nxt,
  output logic       wr_half
);

  logic rd_half;
  logic rel_ok;

  // Release is applied before completion so a half freed this cycle is visible to the full check.
  always_comb begin
    rel_ok   = rel & full[rd_half];
    full_nxt = full;
    if (rel_ok) full_nxt[rd_half] = 1'b0;
    if (cmpl)   full_nxt[wr_half] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full    <= '0;
      wr_half <= 1'b0;
      rd_half <= 1'b0;
    end else if (clr) begin
      full    <= '0;
      wr_half <= 1'b0;
      rd_half <= 1'b0;
    end else begin
      full <= full_nxt;
      if (cmpl)   wr_half <= ~wr_half;
      if (rel_ok) rd_half <= ~rd_half;
    end
  end

endmodule

// File: rtl/fe_buf_wr_ctrl.sv
// Write-side controller: scatters loader beats into the feature banks and ping-pongs two halves.
module fe_buf_wr_ctrl
  import fe_buf_wr_ctrl_pkg::*;
#(
  parameter int unsigned IFM_WIDTH   = FE_IFM_WIDTH,
  parameter int unsigned SCH_COL_NUM = FE_SCH_COL_NUM,
  parameter int unsigned PE_IC_NUM   = FE_PE_IC_NUM,
  parameter int unsigned ADDR_WIDTH  = FE_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             ctrl2buf_layer_start,
  input  logic [14:0]                      tile_in_h,
  input  logic [14:0]                      tile_in_c,
  input  logic [7:0]                       tile_num,
  input  logic                             ld_vld,
  output logic                             ld_rdy,
  input  logic [SCH_COL_NUM*IFM_WIDTH-1:0] ld_dat,
  output logic [PE_IC_NUM-1:0]             fe_buf_wr_en,
  output logic [ADDR_WIDTH-1:0]            fe_buf_wr_addr,
  output logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_buf_wr_dat,
  output logic                             buf2sch_tile_rdy,
  output logic                             buf2sch_tile_half,
  input  logic                             sch2buf_rel,
  output logic                             buf2ctrl_layer_done,
  output logic                             cfg_err
);

  localparam int unsigned RB_W   = ADDR_WIDTH - 1;
  localparam int unsigned BANK_W = (PE_IC_NUM > 1) ? $clog2(PE_IC_NUM) : 1;
  localparam int unsigned HALF   = 1 << RB_W;
  localparam int unsigned DAT_W  = SCH_COL_NUM * IFM_WIDTH;

  logic [1:0]           state;
  logic [14:0]          cfg_h;
  logic [14:0]          cfg_c;
  logic [7:0]           cfg_tiles;
  logic [7:0]           tile_cnt;
  logic [RB_W-1:0]      grp_n;
  logic [RB_W-1:0]      row_base;
  logic [RB_W-1:0]      grp_cnt;
  logic [14:0]          h_cnt;
  logic [14:0]          c_cnt;
  logic [BANK_W-1:0]    bank;
  logic                 cfg_err_q;

  logic [PE_IC_NUM-1:0]  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DAT_W-1:0]      dat_q;
  logic                  tile_rdy_q;
  logic                  tile_half_q;
  logic                  layer_done_q;

  logic [14:0]          grp_n_in;
  logic [29:0]          prod;
  logic                 oversize;
  logic                 accept;
  logic                 last_c;
  logic                 last_h;
  logic                 tile_last;
  logic                 layer_last;
  logic [RB_W-1:0]      addr_low;
  logic [PE_IC_NUM-1:0] bank_oh;

  logic [1:0]           full;
  logic [1:0]           full_nxt;
  logic                 wr_half;
  logic                 clr;

  always_comb begin
    grp_n_in   = ceil_div_ic(tile_in_c, PE_IC_NUM);
    prod       = 30'(grp_n_in) * 30'(tile_in_h);
    oversize   = prod > 30'(HALF);
    ld_rdy     = (state == ST_FILL) & ~full[wr_half];
    // A beat offered alongside layer_start belongs to the aborted layer and is dropped.
    accept     = ld_vld & ld_rdy & ~ctrl2buf_layer_start;
    last_c     = (c_cnt == cfg_c - 15'd1);
    last_h     = (h_cnt == cfg_h - 15'd1);
    tile_last  = accept & last_c & last_h;
    layer_last = ((tile_cnt + 8'd1) == cfg_tiles);
    addr_low   = row_base + grp_cnt;
    clr        = ctrl2buf_layer_start & (state != ST_IDLE);
  end

  // Bank 0 drives the MSB of the enable vector.
  always_comb begin
    bank_oh = '0;
    for (int unsigned i = 0; i < PE_IC_NUM; i++) begin
      bank_oh[PE_IC_NUM-1-i] = (bank == BANK_W'(i));
    end
  end

  fe_buf_half_trk u_half_trk (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .rel      (sch2buf_rel),
    .cmpl     (tile_last),
    .full     (full),
    .full_nxt (full_nxt),
    .wr_half  (wr_half)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cfg_h     <= '0;
      cfg_c     <= '0;
      cfg_tiles <= '0;
      grp_n     <= '0;
      tile_cnt  <= '0;
      h_cnt     <= '0;
      c_cnt     <= '0;
      bank      <= '0;
      grp_cnt   <= '0;
      row_base  <= '0;
      cfg_err_q <= 1'b0;
    end else if (ctrl2buf_layer_start) begin
      cfg_h     <= tile_in_h;
      cfg_c     <= tile_in_c;
      cfg_tiles <= tile_num;
      grp_n     <= grp_n_in[RB_W-1:0];
      tile_cnt  <= '0;
      h_cnt     <= '0;
      c_cnt     <= '0;
      bank      <= '0;
      grp_cnt   <= '0;
      row_base  <= '0;
      cfg_err_q <= oversize;
      state     <= oversize ? ST_IDLE : ST_FILL;
    end else begin
      if (accept) begin
        if (last_c) begin
          c_cnt   <= '0;
          bank    <= '0;
          grp_cnt <= '0;
          if (last_h) begin
            h_cnt    <= '0;
            row_base <= '0;
          end else begin
            h_cnt    <= h_cnt + 15'd1;
            row_base <= row_base + grp_n;
          end
        end else begin
          c_cnt <= c_cnt + 15'd1;
          if (bank == BANK_W'(PE_IC_NUM - 1)) begin
            bank    <= '0;
            grp_cnt <= grp_cnt + RB_W'(1);
          end else begin
            bank <= bank + BANK_W'(1);
          end
        end
      end
      case (state)
        ST_FILL: begin
          if (tile_last) begin
            tile_cnt <= tile_cnt + 8'd1;
            if (layer_last)              state <= ST_IDLE;
            else if (full_nxt[~wr_half]) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!full_nxt[wr_half]) state <= ST_FILL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q      <= '0;
      addr_q       <= '0;
      dat_q        <= '0;
      tile_rdy_q   <= 1'b0;
      tile_half_q  <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      wr_en_q <= accept ? bank_oh : '0;
      if (accept) begin
        addr_q <= {wr_half, addr_low};
        dat_q  <= ld_dat;
      end
      tile_rdy_q   <= tile_last;
      tile_half_q  <= tile_last & wr_half;
      layer_done_q <= tile_last & layer_last;
    end
  end

  assign fe_buf_wr_en        = wr_en_q;
  assign fe_buf_wr_addr      = addr_q;
  assign fe_buf_wr_dat       = dat_q;
  assign buf2sch_tile_rdy    = tile_rdy_q;
  assign buf2sch_tile_half   = tile_half_q;
  assign buf2ctrl_layer_done = layer_done_q;
  assign cfg_err             = cfg_err_q;

endmodule

// File: tb/tb_fe_buf_wr_ctrl.sv
// Scoreboard bench for fe_buf_wr_ctrl: expected writes queued at beat acceptance, compared on output.
`timescale 1ns/1ps
module tb_fe_buf_wr_ctrl;

  localparam int unsigned DW = 320;
  localparam int unsigned AW = 10;
  localparam int unsigned IC = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ctrl2buf_layer_start = 1'b0;
  logic [14:0]   tile_in_h = '0;
  logic [14:0]   tile_in_c = '0;
  logic [7:0]    tile_num = '0;
  logic          ld_vld = 1'b0;
  logic          ld_rdy;
  logic [DW-1:0] ld_dat = '0;
  logic [IC-1:0] fe_buf_wr_en;
  logic [AW-1:0] fe_buf_wr_addr;
  logic [DW-1:0] fe_buf_wr_dat;
  logic          buf2sch_tile_rdy;
  logic          buf2sch_tile_half;
  logic          sch2buf_rel = 1'b0;
  logic          buf2ctrl_layer_done;
  logic          cfg_err;

  always #5 clk = ~clk;

  fe_buf_wr_ctrl #(
    .IFM_WIDTH   (8),
    .SCH_COL_NUM (40),
    .PE_IC_NUM   (4),
    .ADDR_WIDTH  (10)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .ctrl2buf_layer_start (ctrl2buf_layer_start),
    .tile_in_h            (tile_in_h),
    .tile_in_c            (tile_in_c),
    .tile_num             (tile_num),
    .ld_vld               (ld_vld),
    .ld_rdy               (ld_rdy),
    .ld_dat               (ld_dat),
    .fe_buf_wr_en         (fe_buf_wr_en),
    .fe_buf_wr_addr       (fe_buf_wr_addr),
    .fe_buf_wr_dat        (fe_buf_wr_dat),
    .buf2sch_tile_rdy     (buf2sch_tile_rdy),
    .buf2sch_tile_half    (buf2sch_tile_half),
    .sch2buf_rel          (sch2buf_rel),
    .buf2ctrl_layer_done  (buf2ctrl_layer_done),
    .cfg_err              (cfg_err)
  );

  typedef struct {
    logic [IC-1:0] en;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          trdy;
    logic          thalf;
    logic          ldone;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference model of the ping-pong halves and layer activity.
  logic [1:0] m_full = '0;
  logic       m_wr = 1'b0;
  logic       m_rd = 1'b0;
  logic       m_act = 1'b0;
  logic       m_err = 1'b0;

  task automatic chk_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_rdy(input string tag);
    chk_eq(tag, DW'(ld_rdy), DW'(m_act && !m_full[m_wr]));
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (fe_buf_wr_en !== '0) begin
        if (sb.size() == 0) begin
          chk_eq("unexpected_wr", DW'(fe_buf_wr_en), '0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk_eq("wr_en",      DW'(fe_buf_wr_en),        DW'(e.en));
          chk_eq("wr_addr",    DW'(fe_buf_wr_addr),      DW'(e.addr));
          chk_eq("wr_dat",     fe_buf_wr_dat,            e.dat);
          chk_eq("tile_rdy",   DW'(buf2sch_tile_rdy),    DW'(e.trdy));
          chk_eq("tile_half",  DW'(buf2sch_tile_half),   DW'(e.thalf));
          chk_eq("layer_done", DW'(buf2ctrl_layer_done), DW'(e.ldone));
        end
      end else if (buf2sch_tile_rdy || buf2ctrl_layer_done) begin
        chk_eq("stray_pulse", DW'({buf2sch_tile_rdy, buf2ctrl_layer_done}), '0);
      end
    end
  end

  task automatic start_layer(input int unsigned h, input int unsigned c, input int unsigned n);
    tile_in_h = 15'(h);
    tile_in_c = 15'(c);
    tile_num  = 8'(n);
    ctrl2buf_layer_start = 1'b1;
    @(posedge clk);
    if (m_act) begin
      m_full = '0;
      m_wr   = 1'b0;
      m_rd   = 1'b0;
    end
    m_err = (((c + IC - 1) / IC) * h) > 512;
    m_act = !m_err;
    @(negedge clk);
    ctrl2buf_layer_start = 1'b0;
  endtask

  task automatic do_rel();
    sch2buf_rel = 1'b1;
    @(posedge clk);
    if (m_full[m_rd]) begin
      m_full[m_rd] = 1'b0;
      m_rd = ~m_rd;
    end
    @(negedge clk);
    sch2buf_rel = 1'b0;
  endtask

  task automatic beat(input int unsigned h, input int unsigned c, input int unsigned grp,
                      input logic last, input logic ldone, input logic with_rel);
    exp_t e;
    int unsigned guard;
    logic [DW-1:0] d;
    guard = 0;
    for (int unsigned w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    ld_dat = d;
    ld_vld = 1'b1;
    while (!ld_rdy && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!ld_rdy) begin
      chk_eq("rdy_timeout", DW'(ld_rdy), DW'(1));
      ld_vld = 1'b0;
      return;
    end
    e.en    = 4'b1000 >> (c % IC);
    e.addr  = {m_wr, 9'(h * grp + c / IC)};
    e.dat   = d;
    e.trdy  = last;
    e.thalf = last & m_wr;
    e.ldone = ldone;
    sb.push_back(e);
    if (with_rel) sch2buf_rel = 1'b1;
    @(posedge clk);
    if (with_rel && m_full[m_rd]) begin
      m_full[m_rd] = 1'b0;
      m_rd = ~m_rd;
    end
    if (last) begin
      m_full[m_wr] = 1'b1;
      m_wr = ~m_wr;
      if (ldone) m_act = 1'b0;
    end
    @(negedge clk);
    ld_vld = 1'b0;
    sch2buf_rel = 1'b0;
  endtask

  task automatic send_tile(input int unsigned th, input int unsigned tc, input logic ldone,
                           input logic gaps, input logic rel_last);
    int unsigned grp;
    grp = (tc + IC - 1) / IC;
    for (int unsigned h = 0; h < th; h++) begin
      for (int unsigned c = 0; c < tc; c++) begin
        logic last;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        last = (h == th - 1) && (c == tc - 1);
        beat(h, c, grp, last, last && ldone, last && rel_last);
      end
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    chk_eq(tag, DW'(sb.size()), '0);
  endtask

  // Reset asserted mid-phase so any write still presented is caught by the zero check.
  task automatic do_reset();
    #2;
    rstn = 1'b0;
    ld_vld = 1'b0;
    ctrl2buf_layer_start = 1'b0;
    sch2buf_rel = 1'b0;
    #1;
    chk_eq("rst_ctrl", DW'({ld_rdy, fe_buf_wr_en, fe_buf_wr_addr, buf2sch_tile_rdy,
                            buf2sch_tile_half, buf2ctrl_layer_done, cfg_err}), '0);
    chk_eq("rst_dat", fe_buf_wr_dat, '0);
    sb.delete();
    m_full = '0;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    m_act  = 1'b0;
    m_err  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #3;
    chk_eq("init_ctrl", DW'({ld_rdy, fe_buf_wr_en, fe_buf_wr_addr, buf2sch_tile_rdy,
                             buf2sch_tile_half, buf2ctrl_layer_done, cfg_err}), '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_rdy("idle_rdy");

    // Basic single-tile layer, loader always valid
    start_layer(2, 5, 1);
    chk_rdy("basic_rdy");
    send_tile(2, 5, 1'b1, 1'b0, 1'b0);
    drain("basic_drain");
    chk_rdy("basic_done_rdy");

    // Ping-pong stall with an initial release that must be ignored
    do_reset();
    start_layer(1, 4, 3);
    do_rel();
    send_tile(1, 4, 1'b0, 1'b0, 1'b0);
    chk_rdy("pp_rdy_t0");
    send_tile(1, 4, 1'b0, 1'b0, 1'b0);
    chk_rdy("pp_stall");
    repeat (3) @(negedge clk);
    chk_rdy("pp_stall_hold");
    do_rel();
    chk_rdy("pp_resume");
    send_tile(1, 4, 1'b1, 1'b0, 1'b0);
    drain("pp_drain");

    // Release coincident with tile completion
    do_reset();
    start_layer(1, 4, 3);
    send_tile(1, 4, 1'b0, 1'b0, 1'b0);
    send_tile(1, 4, 1'b0, 1'b0, 1'b1);
    chk_rdy("sim_no_wait");
    send_tile(1, 4, 1'b1, 1'b0, 1'b0);
    drain("sim_drain");

    // Random loader gaps
    do_reset();
    start_layer(2, 5, 1);
    send_tile(2, 5, 1'b1, 1'b1, 1'b0);
    drain("gap_drain");

    // Oversize tile and the exact-fit boundary
    do_reset();
    start_layer(300, 8, 1);
    chk_eq("ovs_err", DW'(cfg_err), DW'(m_err));
    chk_rdy("ovs_rdy");
    ld_vld = 1'b1;
    repeat (5) @(negedge clk);
    ld_vld = 1'b0;
    drain("ovs_no_wr");
    start_layer(256, 8, 1);
    chk_eq("fit_err", DW'(cfg_err), DW'(m_err));
    chk_rdy("fit_rdy");
    start_layer(257, 8, 1);
    chk_eq("ovs2_err", DW'(cfg_err), DW'(m_err));
    chk_rdy("ovs2_rdy");
    start_layer(2, 5, 1);
    chk_eq("ovs_clear", DW'(cfg_err), DW'(m_err));
    send_tile(2, 5, 1'b1, 1'b0, 1'b0);
    drain("ovs_drain");

    // Abort mid second tile: halves freed, restart at half 0 address 0
    do_reset();
    start_layer(1, 4, 2);
    send_tile(1, 4, 1'b0, 1'b0, 1'b0);
    beat(0, 0, 1, 1'b0, 1'b0, 1'b0);
    beat(0, 1, 1, 1'b0, 1'b0, 1'b0);
    start_layer(2, 5, 1);
    chk_rdy("abort_rdy");
    send_tile(2, 5, 1'b1, 1'b0, 1'b0);
    drain("abort_drain");

    // Reset while a write is being presented
    do_reset();
    start_layer(2, 5, 1);
    beat(0, 0, 2, 1'b0, 1'b0, 1'b0);
    beat(0, 1, 2, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk_rdy("post_rst_rdy");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fe_buf_wr_ctrl.md
Name: fe_buf_wr_ctrl

Overview:
- Write-side controller for the feature buffer banks that the scheduler reads through fe_olp_buf_rd_en / fe_buf_rd_addr_0..3.
- Accepts an input-feature stream from the loader, one row segment of SCH_COL_NUM pixels of one channel per beat.
- Scatters each beat into the PE_IC_NUM banks and ping-pongs two buffer halves.
- Tells the scheduler when a tile is resident and takes a release back when the scheduler has finished reading that half.

Parameters:
IFM_WIDTH, 8, bits per pixel
SCH_COL_NUM, 40, pixels per beat (row segment incl. overlap columns)
PE_IC_NUM, 4, number of banks; channel c goes to bank c mod PE_IC_NUM
ADDR_WIDTH, 10, bank address width; MSB selects ping-pong half

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ctrl2buf_layer_start  in  1  single-cycle pulse; latches the tile config
tile_in_h  in  15  rows per tile (>=1)
tile_in_c  in  15  channels per tile (>=1)
tile_num  in  8  tiles in the layer (>=1)
ld_vld  in  1  loader beat valid
ld_rdy  out  1  controller ready
ld_dat  in  SCH_COL_NUM*IFM_WIDTH  beat payload
fe_buf_wr_en  out  PE_IC_NUM  one-hot bank write enable; bit PE_IC_NUM-1 = bank 0
fe_buf_wr_addr  out  ADDR_WIDTH  write address, shared by all banks
fe_buf_wr_dat  out  SCH_COL_NUM*IFM_WIDTH  write data
buf2sch_tile_rdy  out  1  one-cycle pulse: a tile is complete in a half
buf2sch_tile_half  out  1  half index qualified by tile_rdy
sch2buf_rel  in  1  one-cycle pulse: scheduler frees the half it is reading (oldest full half)
buf2ctrl_layer_done  out  1  one-cycle pulse after the last tile is written
cfg_err  out  1  sticky; set on an oversize tile, cleared by the next layer_start

Behaviour:
- Reset: all outputs 0; state IDLE; both halves free; write half = 0.
- Beat order on the stream: rows h = 0..tile_in_h-1 outer, channels c = 0..tile_in_c-1 inner.
- Group count: grp_n = ceil(tile_in_c/PE_IC_NUM).
- Beat address: fe_buf_wr_addr = {half, row_base + (c / PE_IC_NUM)}.
  - row_base starts at 0 and advances by grp_n per row, using incremental adders only (no multiplier).
  - Bank = c mod PE_IC_NUM.
- Write latency: a beat is accepted when ld_vld & ld_rdy. wr_en, addr and dat are registered and appear the following cycle for exactly one cycle.
- ld_rdy = (state == FILL) & current write half free. It is combinational from registered state only.
- Layer start: config is latched and grp_n computed. If grp_n*tile_in_h > 2^(ADDR_WIDTH-1):
  - set cfg_err, stay IDLE, ld_rdy stays 0.
  - Otherwise go to FILL; tile counter = 0; cfg_err cleared.
- FSM:
  - IDLE: waits for layer_start.
  - FILL: on the last beat of a tile (h = tile_in_h-1 and c = tile_in_c-1 accepted):
    - mark the half full;
    - pulse tile_rdy with the half index in the cycle the last write is presented;
    - toggle the half; reset h, c and row_base; increment the tile counter.
    - If the tile counter reaches tile_num: pulse layer_done in the same cycle and go to IDLE. Halves are left full for the scheduler to release.
    - Else, if the new half is full: go to WAIT.
  - WAIT: ld_rdy = 0. On sch2buf_rel for the needed half, go to FILL next cycle.
- Release: sch2buf_rel frees the oldest full half (tracked by a read-half pointer that toggles per release).
  - Release with no half full is ignored.
  - Release and tile completion in the same cycle are both applied. Freeing takes effect before the full check, so a tile is never blocked by a half being released in that same cycle.
- layer_start while in FILL or WAIT: aborts the current layer. Counters are cleared, both halves are freed, the new config is latched, and the block proceeds as above.
- Widths: h and c counters are 15 bits; row_base is ADDR_WIDTH-1 bits; wrap is impossible once the oversize check has passed.

Decomposition:
- Shared package holds the constants: half size, bank count, and FSM state encoding IDLE/FILL/WAIT. It also holds the function ceil_div_ic.
- One natural sub-module, fe_buf_half_trk: 2-bit full flags, write pointer and read pointer, with the rel/complete update rules.

Test Plan:
- Basic fill: tile_in_h = 2, tile_in_c = 5, tile_num = 1, loader always valid.
  - 10 writes; grp_n = 2.
  - Row 0: addrs 0,0,0,0,1 with banks 0,1,2,3,0.
  - Row 1: addrs 2,2,2,2,3.
  - tile_rdy with half 0 and layer_done on the cycle of the 10th write.
- Ping-pong stall: tile_num = 3, no release.
  - Tile 0 goes to half 0 (addr MSB 0), tile 1 to half 1 (MSB 1).
  - ld_rdy falls after tile 1.
  - sch2buf_rel resumes writing of tile 2 at MSB 0 the next cycle.
- Simultaneous: release of half 0 in the same cycle tile 1 completes → no WAIT state; ld_rdy stays 1.
- Backpressure/gaps: random ld_vld gaps → write addresses identical to the gap-free run; no writes while ld_vld = 0.
- Oversize: tile_in_c = 8, tile_in_h = 300 (600 > 512) → cfg_err = 1, ld_rdy = 0, no wr_en. A following valid layer_start clears cfg_err.
- Reset/abort:
  - rstn low mid-tile → all outputs 0 immediately.
  - layer_start mid-tile → next beat writes to addr {0,0} of half 0.
